// File: rtl/acq_seg.sv
// Segmented acquisition gate on an AXI4-Stream path: pre/post-trigger segments, TLAST per segment.
// Optional: define ACQ_TIMESTAMP_EN to add cts_i and the acq/trg/stp timestamp capture outputs.
module acq_seg #(
    parameter int unsigned DN = 1,
    parameter int unsigned DW = 14,
    parameter int unsigned TN = 1,
`ifdef ACQ_TIMESTAMP_EN
    parameter int unsigned TW = 64,
`endif
    parameter int unsigned CW = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [DN*DW-1:0] sti_tdata_i,
    input  logic [DN-1:0]    sti_tkeep_i,
    input  logic             sti_tvalid_i,
    output logic             sti_tready_o,
    output logic [DN*DW-1:0] sto_tdata_o,
    output logic [DN-1:0]    sto_tkeep_o,
    output logic             sto_tvalid_o,
    output logic             sto_tlast_o,
    input  logic             sto_tready_i,
    input  logic             ctl_rst_i,
    input  logic             cfg_con_i,
    input  logic             cfg_aut_i,
    input  logic [TN-1:0]    cfg_trg_i,
    input  logic [CW-1:0]    cfg_pre_i,
    input  logic [CW-1:0]    cfg_pst_i,
    input  logic             ctl_acq_i,
    input  logic [TN-1:0]    ctl_trg_i,
    input  logic             ctl_stp_i,
`ifdef ACQ_TIMESTAMP_EN
    input  logic [TW-1:0]    cts_i,
    output logic [TW-1:0]    cts_acq_o,
    output logic [TW-1:0]    cts_trg_o,
    output logic [TW-1:0]    cts_stp_o,
`endif
    output logic             sts_acq_o,
    output logic             sts_trg_o,
    output logic [CW-1:0]    sts_pre_o,
    output logic [CW-1:0]    sts_pst_o,
    output logic [CW-1:0]    sts_seg_o,
    output logic             irq_trg_o,
    output logic             irq_stp_o
);

    typedef enum logic [1:0] {IDLE, PRE, ARM, PST} state_e;

    state_e           state_q, state_d;
    logic             sts_acq_q, sts_trg_q, irq_trg_q, irq_stp_q;
    logic [CW-1:0]    sts_pre_q, sts_pst_q, sts_seg_q;
    logic [CW-1:0]    pre_d, pst_d;
    logic [DN*DW-1:0] tdata_q;
    logic [DN-1:0]    tkeep_q;
    logic             tvalid_q, tlast_q;
    logic             xfer, trig, pre_zero, pst_zero;
    logic             start, stop, trg_acc, seg_end, to_idle, rearm;

    assign sti_tready_o = ~tvalid_q | sto_tready_i;
    assign xfer         = sti_tvalid_i & sti_tready_o;
    assign trig         = (|(ctl_trg_i & cfg_trg_i)) | cfg_aut_i;
    assign pre_zero     = (cfg_pre_i == '0);
    assign pst_zero     = (cfg_pst_i == '0);

    always_comb begin
        pre_d = sts_pre_q;
        if (xfer && (sts_pre_q != '1)) pre_d = sts_pre_q + CW'(1);
        pst_d = sts_pst_q + CW'(xfer);
    end

    // Stop outranks trigger and counter-driven moves; segment end either idles or re-arms.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stop    = 1'b0;
        trg_acc = 1'b0;
        seg_end = 1'b0;
        case (state_q)
            IDLE: if (ctl_acq_i) begin
                start   = 1'b1;
                state_d = pre_zero ? ARM : PRE;
            end
            PRE: begin
                if (ctl_stp_i) stop = 1'b1;
                else if (pre_d >= cfg_pre_i) state_d = ARM;
            end
            ARM: begin
                if (ctl_stp_i) stop = 1'b1;
                else if (trig) begin
                    trg_acc = 1'b1;
                    if (pst_zero) seg_end = 1'b1;
                    else state_d = PST;
                end
            end
            PST: begin
                if (ctl_stp_i) stop = 1'b1;
                else if (xfer && (pst_d >= cfg_pst_i)) seg_end = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (stop) state_d = IDLE;
        if (seg_end) state_d = cfg_con_i ? (pre_zero ? ARM : PRE) : IDLE;
        rearm   = seg_end & cfg_con_i;
        to_idle = stop | (seg_end & ~cfg_con_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            sts_acq_q <= 1'b0;
            sts_trg_q <= 1'b0;
            irq_trg_q <= 1'b0;
            irq_stp_q <= 1'b0;
            sts_pre_q <= '0;
            sts_pst_q <= '0;
            sts_seg_q <= '0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else if (ctl_rst_i) begin
            state_q   <= IDLE;
            sts_acq_q <= 1'b0;
            sts_trg_q <= 1'b0;
            irq_trg_q <= 1'b0;
            irq_stp_q <= 1'b0;
            sts_pre_q <= '0;
            sts_pst_q <= '0;
            sts_seg_q <= '0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sts_acq_q <= (state_d != IDLE);
            sts_trg_q <= (state_d == PST);
            irq_trg_q <= trg_acc;
            irq_stp_q <= to_idle;

            if (start || rearm) begin
                sts_pre_q <= '0;
                sts_pst_q <= '0;
            end else if ((state_q == PRE) || (state_q == ARM)) begin
                sts_pre_q <= pre_d;
            end else if (state_q == PST) begin
                sts_pst_q <= pst_d;
            end

            if (start) sts_seg_q <= '0;
            else if (trg_acc) sts_seg_q <= sts_seg_q + CW'(1);

            // IDLE beats are consumed but never loaded; a stop cycle forwards its beat without TLAST.
            if (sto_tready_i) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
            if (xfer && (state_q != IDLE)) begin
                tvalid_q <= 1'b1;
                tdata_q  <= sti_tdata_i;
                tkeep_q  <= sti_tkeep_i;
                tlast_q  <= seg_end;
            end
        end
    end

`ifdef ACQ_TIMESTAMP_EN
    logic [TW-1:0] cts_acq_q, cts_trg_q, cts_stp_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cts_acq_q <= '0;
            cts_trg_q <= '0;
            cts_stp_q <= '0;
        end else if (ctl_rst_i) begin
            cts_acq_q <= '0;
            cts_trg_q <= '0;
            cts_stp_q <= '0;
        end else begin
            if (start)   cts_acq_q <= cts_i;
            if (trg_acc) cts_trg_q <= cts_i;
            if (to_idle) cts_stp_q <= cts_i;
        end
    end

    assign cts_acq_o = cts_acq_q;
    assign cts_trg_o = cts_trg_q;
    assign cts_stp_o = cts_stp_q;
`endif

    assign sto_tdata_o  = tdata_q;
    assign sto_tkeep_o  = tkeep_q;
    assign sto_tvalid_o = tvalid_q;
    assign sto_tlast_o  = tlast_q;
    assign sts_acq_o    = sts_acq_q;
    assign sts_trg_o    = sts_trg_q;
    assign sts_pre_o    = sts_pre_q;
    assign sts_pst_o    = sts_pst_q;
    assign sts_seg_o    = sts_seg_q;
    assign irq_trg_o    = irq_trg_q;
    assign irq_stp_o    = irq_stp_q;

endmodule

// File: tb/tb_acq_seg.sv
// Directed bench for acq_seg: idle drop, single segment, early trigger, continuous, stall/stop, pst=0, soft reset.
module tb_acq_seg;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic [13:0]   sti_tdata, sto_tdata;
    logic [0:0]    sti_tkeep, sto_tkeep;
    logic          sti_tvalid, sti_tready, sto_tvalid, sto_tlast, sto_tready;
    logic          ctl_rst, cfg_con, cfg_aut, ctl_acq, ctl_stp;
    logic [0:0]    cfg_trg, ctl_trg;
    logic [CW-1:0] cfg_pre, cfg_pst, sts_pre, sts_pst, sts_seg;
    logic          sts_acq, sts_trg, irq_trg, irq_stp;
`ifdef ACQ_TIMESTAMP_EN
    logic [63:0]   cts = '0, cts_acq, cts_trg, cts_stp;
    always @(posedge clk) cts <= cts + 64'd1;
`endif

    int   n_chk = 0, n_fail = 0;
    int   out_d[$];
    logic out_l[$];
    int   exp_d[$];
    logic exp_l[$];
    int   n_istp = 0, n_itrg = 0;
    int   base, istp0, itrg0;

    acq_seg #(.DN(1), .DW(14), .TN(1), .CW(CW)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .sti_tdata_i(sti_tdata), .sti_tkeep_i(sti_tkeep), .sti_tvalid_i(sti_tvalid), .sti_tready_o(sti_tready),
        .sto_tdata_o(sto_tdata), .sto_tkeep_o(sto_tkeep), .sto_tvalid_o(sto_tvalid), .sto_tlast_o(sto_tlast),
        .sto_tready_i(sto_tready),
        .ctl_rst_i(ctl_rst), .cfg_con_i(cfg_con), .cfg_aut_i(cfg_aut), .cfg_trg_i(cfg_trg),
        .cfg_pre_i(cfg_pre), .cfg_pst_i(cfg_pst), .ctl_acq_i(ctl_acq), .ctl_trg_i(ctl_trg), .ctl_stp_i(ctl_stp),
`ifdef ACQ_TIMESTAMP_EN
        .cts_i(cts), .cts_acq_o(cts_acq), .cts_trg_o(cts_trg), .cts_stp_o(cts_stp),
`endif
        .sts_acq_o(sts_acq), .sts_trg_o(sts_trg), .sts_pre_o(sts_pre), .sts_pst_o(sts_pst),
        .sts_seg_o(sts_seg), .irq_trg_o(irq_trg), .irq_stp_o(irq_stp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        int v;
        if (sto_tvalid && sto_tready) begin
            v = $signed(sto_tdata);
            out_d.push_back(v);
            out_l.push_back(sto_tlast);
        end
        if (irq_stp) n_istp++;
        if (irq_trg) n_itrg++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input int v, input logic t, input int gap);
        int n;
        n = 0;
        sti_tvalid = 1'b1;
        sti_tdata  = 14'(v);
        ctl_trg    = t;
        forever begin
            @(negedge clk);
            if (sti_tready) break;
            step();
            n++;
            if (n > 64) begin
                check("tready_wait", {63'd0, sti_tready}, 64'd1);
                break;
            end
        end
        step();
        sti_tvalid = 1'b0;
        ctl_trg    = 1'b0;
        idle(gap);
    endtask

    task automatic expect_beat(input int v, input logic l);
        exp_d.push_back(v);
        exp_l.push_back(l);
    endtask

    task automatic cmp_out(input string tag, input int b);
        check({tag, "_count"}, 64'(out_d.size() - b), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && (b + i) < out_d.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 64'(out_d[b+i]), 64'(exp_d[i]));
            check($sformatf("%s_last%0d", tag, i), {63'd0, out_l[b+i]}, {63'd0, exp_l[i]});
        end
        exp_d.delete();
        exp_l.delete();
    endtask

    task automatic mark();
        base  = out_d.size();
        istp0 = n_istp;
        itrg0 = n_itrg;
    endtask

    task automatic pulse_acq();
        ctl_acq = 1'b1;
        step();
        ctl_acq = 1'b0;
    endtask

    task automatic pulse_stp();
        ctl_stp = 1'b1;
        step();
        ctl_stp = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; sti_tdata = '0; sti_tkeep = 1'b1; sti_tvalid = 1'b0; sto_tready = 1'b1;
        ctl_rst = 1'b0; cfg_con = 1'b0; cfg_aut = 1'b0; cfg_trg = 1'b1; ctl_trg = 1'b0;
        cfg_pre = '0; cfg_pst = '0; ctl_acq = 1'b0; ctl_stp = 1'b0;
        idle(2);
        check("rst_tvalid", {63'd0, sto_tvalid}, 64'd0);
        check("rst_tlast", {63'd0, sto_tlast}, 64'd0);
        check("rst_acq", {63'd0, sts_acq}, 64'd0);
        check("rst_seg", 64'(sts_seg), 64'd0);
        check("rst_pre", 64'(sts_pre), 64'd0);
        check("rst_irq", {62'd0, irq_trg, irq_stp}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        check("rst_tready", {63'd0, sti_tready}, 64'd1);

        // Idle drop
        mark();
        for (int v = -8; v <= 8; v++) send(v, 1'b0, 0);
        idle(3);
        cmp_out("idle", base);
        check("idle_irq_stp", 64'(n_istp - istp0), 64'd0);
        check("idle_acq", {63'd0, sts_acq}, 64'd0);

        // Single segment: pre=4, pst=3, trigger with sample 6
        cfg_pre = 32'd4; cfg_pst = 32'd3;
        mark();
        pulse_acq();
        check("seg_acq_on", {63'd0, sts_acq}, 64'd1);
        for (int v = 0; v <= 7; v++) send(v, v == 6, 0);
        check("seg_trg_state", {63'd0, sts_trg}, 64'd1);
        check("seg_pst_mid", 64'(sts_pst), 64'd1);
        check("seg_seg_mid", 64'(sts_seg), 64'd1);
        for (int v = 8; v <= 15; v++) send(v, 1'b0, 0);
        idle(3);
        for (int v = 0; v <= 9; v++) expect_beat(v, v == 9);
        cmp_out("seg", base);
        check("seg_irq_stp", 64'(n_istp - istp0), 64'd1);
        check("seg_irq_trg", 64'(n_itrg - itrg0), 64'd1);
        check("seg_acq_off", {63'd0, sts_acq}, 64'd0);
        check("seg_pre", 64'(sts_pre), 64'd7);
        check("seg_pst", 64'(sts_pst), 64'd3);

        // Early trigger ignored in PRE, no auto: stays armed
        cfg_pre = 32'd8;
        mark();
        pulse_acq();
        check("early_seg_clr", 64'(sts_seg), 64'd0);
        for (int v = 0; v <= 14; v++) send(v, v == 2, 0);
        idle(2);
        for (int v = 0; v <= 14; v++) expect_beat(v, 1'b0);
        cmp_out("early", base);
        check("early_acq", {63'd0, sts_acq}, 64'd1);
        check("early_seg", 64'(sts_seg), 64'd0);
        check("early_pre", 64'(sts_pre), 64'd15);
        check("early_irq_trg", 64'(n_itrg - itrg0), 64'd0);
        pulse_stp();
        idle(2);
        check("early_stop_acq", {63'd0, sts_acq}, 64'd0);
        check("early_stop_irq", 64'(n_istp - istp0), 64'd1);
        pulse_stp();
        idle(2);
        check("idle_stop_noirq", 64'(n_istp - istp0), 64'd1);

        // Continuous auto-trigger, pre=2, pst=2
        cfg_con = 1'b1; cfg_aut = 1'b1; cfg_pre = 32'd2; cfg_pst = 32'd2;
        mark();
        pulse_acq();
        for (int v = 0; v <= 11; v++) send(v, 1'b0, 1);
        idle(1);
        for (int v = 0; v <= 11; v++) expect_beat(v, (v % 4) == 3);
        cmp_out("cont", base);
        check("cont_seg", 64'(sts_seg), 64'd3);
        check("cont_irq_trg", 64'(n_itrg - itrg0), 64'd3);
        check("cont_irq_stp", 64'(n_istp - istp0), 64'd0);
        check("cont_acq", {63'd0, sts_acq}, 64'd1);
        cfg_con = 1'b0; cfg_aut = 1'b0;
        pulse_stp();
        idle(2);
        check("cont_stop_irq", 64'(n_istp - istp0), 64'd1);

        // Backpressure stalls counting; stop keeps held beat, no TLAST
        cfg_pre = 32'd16; cfg_pst = 32'd3;
        mark();
        sto_tready = 1'b0;
        pulse_acq();
        send(0, 1'b0, 0);
        sti_tvalid = 1'b1; sti_tdata = 14'd1;
        idle(3);
        check("stall_pre", 64'(sts_pre), 64'd1);
        check("stall_tready", {63'd0, sti_tready}, 64'd0);
        check("stall_hold", 64'(sto_tdata), 64'd0);
        sto_tready = 1'b1;
        step();
        sti_tvalid = 1'b0;
        check("stall_pre_resume", 64'(sts_pre), 64'd2);
        for (int v = 2; v <= 4; v++) send(v, 1'b0, 0);
        sto_tready = 1'b0;
        pulse_stp();
        check("stop_acq", {63'd0, sts_acq}, 64'd0);
        check("stop_held_valid", {63'd0, sto_tvalid}, 64'd1);
        check("stop_held_data", 64'(sto_tdata), 64'd4);
        check("stop_held_keep", {63'd0, sto_tkeep}, 64'd1);
        sto_tready = 1'b1;
        idle(2);
        for (int v = 0; v <= 4; v++) expect_beat(v, 1'b0);
        cmp_out("stop", base);
        check("stop_irq", 64'(n_istp - istp0), 64'd1);
        check("stop_pre", 64'(sts_pre), 64'd5);

        // pre=0 arms directly; masked trigger ignored; pst=0 ends on the trigger beat
        cfg_pre = '0; cfg_pst = '0; cfg_trg = 1'b0;
        mark();
        pulse_acq();
        check("p0_acq", {63'd0, sts_acq}, 64'd1);
        check("p0_trg", {63'd0, sts_trg}, 64'd0);
        send(4, 1'b1, 0);
        check("p0_masked_seg", 64'(sts_seg), 64'd0);
        cfg_trg = 1'b1;
        send(5, 1'b1, 0);
        idle(2);
        expect_beat(4, 1'b0);
        expect_beat(5, 1'b1);
        cmp_out("p0", base);
        check("p0_seg", 64'(sts_seg), 64'd1);
        check("p0_acq_off", {63'd0, sts_acq}, 64'd0);
        check("p0_irq_stp", 64'(n_istp - istp0), 64'd1);
        check("p0_irq_trg", 64'(n_itrg - itrg0), 64'd1);
        check("p0_pre", 64'(sts_pre), 64'd2);
        check("p0_pst", 64'(sts_pst), 64'd0);
`ifdef ACQ_TIMESTAMP_EN
        check("ts_gap", cts_trg - cts_acq, 64'd2);
`endif

        // Soft reset clears state and output register
        cfg_pre = 32'd4; cfg_pst = 32'd3;
        sto_tready = 1'b0;
        pulse_acq();
        send(1, 1'b0, 0);
        check("srst_pre_valid", {63'd0, sto_tvalid}, 64'd1);
        ctl_rst = 1'b1;
        step();
        ctl_rst = 1'b0;
        check("srst_acq", {63'd0, sts_acq}, 64'd0);
        check("srst_valid", {63'd0, sto_tvalid}, 64'd0);
        check("srst_pre", 64'(sts_pre), 64'd0);
        check("srst_tready", {63'd0, sti_tready}, 64'd1);
        sto_tready = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
